// File: rtl/sram_port_arbiter.sv
// Purpose: owns the external 16-bit SRAM, serialising recorder writes and DSP reads, with strobe/DQ control and recorded-extent tracking.
// Latency: ack pulses WAIT_CYC+1 cycles after the grant cycle; back-to-back throughput is one access per WAIT_CYC+2 cycles.
// Backpressure: level requests are held until their ack; writes beat reads (round-robin when SRAM_RR_ARB_EN is defined).
module sram_port_arbiter #(
    parameter int                ADDR_W   = 20,
    parameter int                DATA_W   = 16,
    parameter int                WAIT_CYC = 2,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_clr_end,
    output logic [ADDR_W-1:0] o_rec_end,
    output logic              o_full,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_READ    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    // Counter value of the final strobe cycle.
    localparam logic [3:0]     LAST_CNT = 4'(WAIT_CYC - 1);
    // Highest value the recorded extent may take.
    localparam logic [ADDR_W:0] END_LIM = {1'b0, MAX_ADDR} + (ADDR_W+1)'(1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] wdat_q;
    logic              dir_wr_q;   // latched direction of the access in flight
    logic              ok_q;       // access touches the SRAM (in range)
    logic              gnt;
    logic              pick_wr;
    logic              rd_cap;
    logic              dq_oe;
    logic              grant_ok;
    logic [ADDR_W:0]   wr_end;
    logic [ADDR_W:0]   sat_end;
    logic [ADDR_W-1:0] rec_base;
    logic [ADDR_W-1:0] rec_nxt;
    logic              full_nxt;

`ifdef SRAM_RR_ARB_EN
    logic last_rd_q;  // 1 = read was granted last

    // Contended grant goes to whoever was not served last.
    always_comb begin
        pick_wr = i_wr_req && (!i_rd_req || last_rd_q);
    end

    // Remember the direction of every grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_rd_q <= 1'b1;
        end else if (gnt) begin
            last_rd_q <= !pick_wr;
        end
    end
`else
    // Writes always win so recording never drops samples.
    always_comb begin
        pick_wr = i_wr_req;
    end
`endif

    // In-range check for the request being granted this cycle.
    always_comb begin
        grant_ok = pick_wr ? (i_wr_addr <= MAX_ADDR) : (i_rd_addr < o_rec_end);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and SRAM strobes decoded from the registered state.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        gnt         = 1'b0;
        rd_cap      = 1'b0;
        dq_oe       = 1'b0;
        o_SRAM_CE_N = 1'b1;
        o_SRAM_WE_N = 1'b1;
        o_SRAM_OE_N = 1'b1;
        o_wr_ack    = 1'b0;
        o_rd_ack    = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_wr_req || i_rd_req) begin
                    gnt       = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = pick_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                o_SRAM_CE_N = 1'b0;
                o_SRAM_WE_N = !ok_q;
                dq_oe       = ok_q;
                if (cnt == LAST_CNT) state_nxt = S_RECOVER;
                else                 cnt_nxt   = cnt + 4'd1;
            end
            S_READ: begin
                o_SRAM_CE_N = 1'b0;
                o_SRAM_OE_N = !ok_q;
                if (cnt == LAST_CNT) begin
                    rd_cap    = 1'b1;
                    state_nxt = S_RECOVER;
                end else begin
                    cnt_nxt   = cnt + 4'd1;
                end
            end
            S_RECOVER: begin
                // CE stays low and write data stays driven for hold time.
                o_SRAM_CE_N = 1'b0;
                dq_oe       = dir_wr_q && ok_q;
                o_wr_ack    = dir_wr_q;
                o_rd_ack    = !dir_wr_q;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_busy      = (state != S_IDLE);
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;
    assign io_SRAM_DQ  = dq_oe ? wdat_q : {DATA_W{1'bz}};

    // Extent update: a clear in the ack cycle applies before the write.
    always_comb begin
        wr_end   = {1'b0, o_SRAM_ADDR} + (ADDR_W+1)'(1);
        sat_end  = (wr_end > END_LIM) ? END_LIM : wr_end;
        rec_base = i_clr_end ? '0 : o_rec_end;
        rec_nxt  = rec_base;
        if (o_wr_ack && ok_q && ({1'b0, rec_base} < sat_end)) begin
            rec_nxt = sat_end[ADDR_W-1:0];
        end
        full_nxt = (o_wr_ack && !ok_q) ? 1'b1 : (i_clr_end ? 1'b0 : o_full);
    end

    // Latch the granted request, capture read data, track extent and overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_SRAM_ADDR <= '0;
            wdat_q      <= '0;
            dir_wr_q    <= 1'b0;
            ok_q        <= 1'b0;
            o_rd_data   <= '0;
            o_rec_end   <= '0;
            o_full      <= 1'b0;
        end else begin
            if (gnt) begin
                o_SRAM_ADDR <= pick_wr ? i_wr_addr : i_rd_addr;
                dir_wr_q    <= pick_wr;
                ok_q        <= grant_ok;
                if (pick_wr) wdat_q <= i_wr_data;
            end
            if (rd_cap) begin
                o_rd_data <= ok_q ? io_SRAM_DQ : '0;
            end
            o_rec_end <= rec_nxt;
            o_full    <= full_nxt;
        end
    end

endmodule
